// File: rtl/fetch_unit.sv
// RV32I instruction-fetch stage: owns the PC, addresses imem, and hands {pc, instr}
// pairs to decode through a 2-entry valid/ready buffer with redirect and sticky fault.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault,
  output logic [31:0] fault_pc,
  output logic [31:0] fetch_count
);

  localparam logic [29:0] DEPTH_IDX = 30'(IMEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;
  logic        fault_q, fault_d;
  logic [31:0] fault_pc_q, fault_pc_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] buf_pc_q    [2];
  logic [31:0] buf_instr_q [2];

  logic pop, push, pc_bad, target_bad, fetch_ok;

  always_comb begin
    out_valid  = (count_q != 2'd0);
    pop        = out_valid & out_ready;
    pc_bad     = (pc_q[1:0] != 2'b00) | (pc_q[31:2] >= DEPTH_IDX);
    target_bad = (redirect_target[1:0] != 2'b00) | (redirect_target[31:2] >= DEPTH_IDX);
    fetch_ok   = !fault_q & ((count_q < 2'd2) | pop) & !pc_bad;
    push       = !redirect_valid & fetch_ok;
  end

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    pc_d          = pc_q;
    count_d       = count_q;
    head_d        = head_q;
    tail_d        = tail_q;
    fault_d       = fault_q;
    fault_pc_d    = fault_pc_q;
    fetch_count_d = fetch_count_q + {31'd0, pop};

    if (redirect_valid) begin
      count_d = 2'd0;
      head_d  = 1'b0;
      tail_d  = 1'b0;
      pc_d    = redirect_target;
      if (target_bad && !fault_q) begin
        fault_d    = 1'b1;
        fault_pc_d = redirect_target;
      end
    end else begin
      if (pop)  head_d = ~head_q;
      if (push) begin
        tail_d = ~tail_q;
        pc_d   = pc_q + 32'd4;
      end
      count_d = count_q + 2'(push) - 2'(pop);
      if (pc_bad && !fault_q) begin
        fault_d    = 1'b1;
        fault_pc_d = pc_q;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      head_q        <= 1'b0;
      tail_q        <= 1'b0;
      fault_q       <= 1'b0;
      fault_pc_q    <= 32'd0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      fault_q       <= fault_d;
      fault_pc_q    <= fault_pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q gates every read, so stale contents never escape.
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc_q[tail_q]    <= pc_q;
      buf_instr_q[tail_q] <= imem_instr;
    end
  end

  assign imem_pc     = pc_q;
  assign out_pc      = out_valid ? buf_pc_q[head_q]    : 32'd0;
  assign out_instr   = out_valid ? buf_instr_q[head_q] : 32'd0;
  assign fault       = fault_q;
  assign fault_pc    = fault_pc_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_fetch_unit;

  localparam int unsigned DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_pc, imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr, fault_pc, fetch_count;
  logic        fault;

  logic [31:0] s_imem_pc, s_imem_instr, s_out_pc, s_out_instr, s_fault_pc, s_fetch_count;
  logic        s_redirect_valid = 1'b0;
  logic [31:0] s_redirect_target = 32'd0;
  logic        s_out_valid, s_out_ready = 1'b1, s_fault;

  logic [31:0] imem [DEPTH];

  assign imem_instr   = imem[imem_pc[9:2]];
  assign s_imem_instr = imem[s_imem_pc[9:2]];

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_pc(imem_pc), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .fault(fault), .fault_pc(fault_pc), .fetch_count(fetch_count)
  );

  fetch_unit #(.RESET_PC(32'h0), .IMEM_DEPTH(4)) u_small (
    .clk(clk), .rst_n(rst_n), .imem_pc(s_imem_pc), .imem_instr(s_imem_instr),
    .redirect_valid(s_redirect_valid), .redirect_target(s_redirect_target),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_pc(s_out_pc), .out_instr(s_out_instr),
    .fault(s_fault), .fault_pc(s_fault_pc), .fetch_count(s_fetch_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of delivered-but-unconsumed fetches plus the architectural PC.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } entry_t;
  entry_t      mq[$];
  logic [31:0] m_pc, m_fault_pc, m_fc;
  bit          m_fault;

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= DEPTH);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'd0; m_fault = 1'b0; m_fault_pc = 32'd0; m_fc = 32'd0;
  endtask

  task automatic model_step();
    int     sz;
    bit     pop;
    entry_t e;
    sz  = mq.size();
    pop = (sz > 0) && out_ready;
    if (pop) begin
      m_fc = m_fc + 1;
      void'(mq.pop_front());
    end
    if (redirect_valid) begin
      mq.delete();
      if (!m_fault && addr_bad(redirect_target)) begin
        m_fault = 1'b1; m_fault_pc = redirect_target;
      end
      m_pc = redirect_target;
    end else if (!m_fault) begin
      if (addr_bad(m_pc)) begin
        m_fault = 1'b1; m_fault_pc = m_pc;
      end else if (sz < 2 || pop) begin
        e.pc = m_pc; e.instr = imem[(m_pc / 4) % DEPTH];
        mq.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic compare_model(input string tag);
    bit v;
    v = mq.size() > 0;
    check({tag, ".out_valid"},   {31'd0, out_valid}, {31'd0, v});
    check({tag, ".out_pc"},      out_pc,      v ? mq[0].pc    : 32'd0);
    check({tag, ".out_instr"},   out_instr,   v ? mq[0].instr : 32'd0);
    check({tag, ".imem_pc"},     imem_pc,     m_pc);
    check({tag, ".fault"},       {31'd0, fault}, {31'd0, m_fault});
    check({tag, ".fault_pc"},    fault_pc,    m_fault_pc);
    check({tag, ".fetch_count"}, fetch_count, m_fc);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Asserts reset away from the clock edge, checks outputs while still in reset,
  // and releases on the falling edge so the next rising edge is the first fetch.
  task automatic do_reset();
    redirect_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("rst.out_valid",   {31'd0, out_valid}, 32'd0);
    check("rst.out_pc",      out_pc, 32'd0);
    check("rst.out_instr",   out_instr, 32'd0);
    check("rst.imem_pc",     imem_pc, 32'd0);
    check("rst.fault",       {31'd0, fault}, 32'd0);
    check("rst.fault_pc",    fault_pc, 32'd0);
    check("rst.fetch_count", fetch_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          rst;
    bit          rv;
    logic [31:0] tgt;
    bit          rdy;
    bit          e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_imem;
    bit          e_fault;
    logic [31:0] e_fpc;
    logic [31:0] e_cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit rv, input logic [31:0] tgt, input bit rdy,
                     input bit ev, input logic [31:0] epc, input logic [31:0] eim,
                     input bit ef, input logic [31:0] efpc, input logic [31:0] ecnt);
    vec_t v;
    v.rst = rst; v.rv = rv; v.tgt = tgt; v.rdy = rdy; v.e_valid = ev; v.e_pc = epc;
    v.e_imem = eim; v.e_fault = ef; v.e_fpc = efpc; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) imem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0013);
    imem[0] = 32'h0000_0013; imem[1] = 32'h0010_0093;
    imem[2] = 32'h0020_0113; imem[3] = 32'h0030_0193;

    // rst rv tgt rdy | valid pc imem_pc fault fault_pc fetch_count
    // sequential delivery
    add(1,0,0,1, 0,0,0,0,0,0);       add(0,0,0,1, 1,0,4,0,0,0);
    add(0,0,0,1, 1,4,8,0,0,1);       add(0,0,0,1, 1,8,12,0,0,2);
    add(0,0,0,1, 1,12,16,0,0,3);     add(0,0,0,1, 1,16,20,0,0,4);
    // backpressure fills the buffer, then drains in order
    add(1,0,0,0, 0,0,0,0,0,0);       add(0,0,0,0, 1,0,4,0,0,0);
    add(0,0,0,0, 1,0,8,0,0,0);       add(0,0,0,0, 1,0,8,0,0,0);
    add(0,0,0,0, 1,0,8,0,0,0);       add(0,0,0,1, 1,0,8,0,0,0);
    add(0,0,0,1, 1,4,12,0,0,1);      add(0,0,0,1, 1,8,16,0,0,2);
    add(0,0,0,1, 1,12,20,0,0,3);
    // redirect to 0x40 while pc 8 is accepted
    add(1,0,0,1, 0,0,0,0,0,0);       add(0,0,0,1, 1,0,4,0,0,0);
    add(0,0,0,1, 1,4,8,0,0,1);       add(0,1,32'h40,1, 1,8,12,0,0,2);
    add(0,0,0,1, 0,0,32'h40,0,0,3);  add(0,0,0,1, 1,32'h40,32'h44,0,0,3);
    add(0,0,0,1, 1,32'h44,32'h48,0,0,4);
    // misaligned redirect faults; a later good redirect leaves the fault set
    add(1,0,0,1, 0,0,0,0,0,0);       add(0,1,32'h42,1, 1,0,4,0,0,0);
    add(0,0,0,1, 0,0,32'h42,1,32'h42,1); add(0,1,32'h10,1, 0,0,32'h42,1,32'h42,1);
    add(0,0,0,1, 0,0,32'h10,1,32'h42,1); add(0,0,0,1, 0,0,32'h10,1,32'h42,1);
    // last in-range word, then sequential run off the end of imem
    add(1,0,0,1, 0,0,0,0,0,0);       add(0,1,32'h3FC,1, 1,0,4,0,0,0);
    add(0,0,0,1, 0,0,32'h3FC,0,0,1); add(0,0,0,1, 1,32'h3FC,32'h400,0,0,1);
    add(0,0,0,1, 0,0,32'h400,1,32'h400,2); add(0,0,0,1, 0,0,32'h400,1,32'h400,2);

    #1;
    do_reset();
    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      out_ready       = vecs[i].rdy;
      #2;
      check($sformatf("vec%0d.out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      check($sformatf("vec%0d.out_pc", i), out_pc, vecs[i].e_pc);
      check($sformatf("vec%0d.out_instr", i), out_instr,
            vecs[i].e_valid ? imem[(vecs[i].e_pc / 4) % DEPTH] : 32'd0);
      check($sformatf("vec%0d.imem_pc", i), imem_pc, vecs[i].e_imem);
      check($sformatf("vec%0d.fault", i), {31'd0, fault}, {31'd0, vecs[i].e_fault});
      check($sformatf("vec%0d.fault_pc", i), fault_pc, vecs[i].e_fpc);
      check($sformatf("vec%0d.fetch_count", i), fetch_count, vecs[i].e_cnt);
      compare_model($sformatf("vec%0d.model", i));
      cycle();
    end

    // Four-word imem: pc 0..12 delivered, then fault at 0x10 and silence.
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    s_out_ready = 1'b1;
    do_reset();
    #2;
    check("small.pre_valid", {31'd0, s_out_valid}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check($sformatf("small%0d.valid", k), {31'd0, s_out_valid}, 32'd1);
      check($sformatf("small%0d.pc", k), s_out_pc, 32'(4 * k));
      check($sformatf("small%0d.instr", k), s_out_instr, imem[k]);
      check($sformatf("small%0d.fault", k), {31'd0, s_fault}, 32'd0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("small_end%0d.valid", k), {31'd0, s_out_valid}, 32'd0);
      check($sformatf("small_end%0d.fault", k), {31'd0, s_fault}, 32'd1);
      check($sformatf("small_end%0d.fault_pc", k), s_fault_pc, 32'h10);
      check($sformatf("small_end%0d.count", k), s_fetch_count, 32'd4);
      check($sformatf("small_end%0d.imem_pc", k), s_imem_pc, 32'h10);
    end

    // Reset asserted mid-cycle with the buffer full, then fetch resumes from RESET_PC.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) cycle();
    #2;
    check("midrst.full_valid", {31'd0, out_valid}, 32'd1);
    check("midrst.full_imem_pc", imem_pc, 32'd8);
    do_reset();
    out_ready = 1'b1;
    #2;
    compare_model("midrst.after0");
    cycle();
    #2;
    check("midrst.resume_pc", out_pc, 32'd0);
    check("midrst.resume_instr", out_instr, imem[0]);
    compare_model("midrst.after1");

    // Randomized traffic against the reference model.
    for (int i = 4; i < int'(DEPTH); i++) imem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((n % 400 == 399) || (m_fault && ($urandom % 8 == 0))) do_reset();
      redirect_valid = ($urandom % 16 == 0);
      case ($urandom % 10)
        0, 1, 2, 3, 4, 5, 6: redirect_target = {22'd0, 8'($urandom), 2'b00};
        7:                   redirect_target = 32'((248 + $urandom % 8) * 4);
        8:                   redirect_target = {22'd0, 8'($urandom), 2'b01 + 2'($urandom % 3)};
        default:             redirect_target = $urandom | 32'h0000_0400;
      endcase
      out_ready = ($urandom % 4 != 0);
      #2;
      compare_model($sformatf("rnd%0d", n));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RV32I core, directly upstream of the instruction memory. Owns the program counter, drives the word-aligned fetch address to `imem`, captures the returned instruction, and delivers `{pc, instr}` pairs to decode through a 2-entry valid/ready buffer. Also handles redirects from branch/jump resolution and raises a sticky fault on misaligned or out-of-range fetch addresses.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `IMEM_DEPTH`, 256, instruction memory depth in 32-bit words; fetch index `pc[31:2]` must be `< IMEM_DEPTH`.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_pc` out 32: fetch address to `imem` (equals internal PC register).
- `imem_instr` in 32: instruction returned combinationally by `imem` for `imem_pc`.
- `redirect_valid` in 1: load a new PC this cycle (taken branch/jump).
- `redirect_target` in 32: new PC when `redirect_valid`=1.
- `out_valid` out 1: buffer head holds a valid instruction.
- `out_ready` in 1: decode accepts the head this cycle.
- `out_pc` out 32: PC of head entry.
- `out_instr` out 32: instruction of head entry.
- `fault` out 1: sticky fetch fault.
- `fault_pc` out 32: offending PC, captured when `fault` sets.
- `fetch_count` out 32: number of completed output handshakes, wraps modulo 2^32.

## Operation
- State: PC register, 2-entry FIFO of `{pc, instr}` (head/tail pointers + 2-bit count), fault flag, fault_pc, fetch_count.
- `pop` = `out_valid & out_ready`. `fetch_ok` = `!fault & (count < 2 | pop)` and PC index `< IMEM_DEPTH` and `pc[1:0]==0`.
- Normal cycle (no redirect): if `fetch_ok`, push `{pc, imem_instr}` and PC ← PC+4 (32-bit wrap). Otherwise PC holds.
- PC out of range (`pc[31:2] >= IMEM_DEPTH`) with no redirect: no push; fault ← 1, fault_pc ← PC. Entries already in the FIFO still drain normally.
- Redirect (priority over fetch): FIFO flushed (count ← 0, pointers ← 0), no push this cycle, a same-cycle `pop` still counts as completed (fetch_count increments). If `redirect_target[1:0] != 0` or target index `>= IMEM_DEPTH`: fault ← 1, fault_pc ← target, PC ← target. Otherwise PC ← target.
- Redirect while `fault`=1: PC and FIFO updated as above; fault stays set. Fault clears only on reset.
- While `fault`=1: no further pushes; `out_valid` drops once FIFO empties.
- Simultaneous push and pop at count=2: count stays 2, head advances.
- `out_pc`/`out_instr` are 0 whenever `out_valid`=0.

## Timing
- Reset (async assert, sync to next edge on deassert): PC=RESET_PC, `imem_pc`=RESET_PC, FIFO empty, `out_valid`=0, `out_pc`=0, `out_instr`=0, `fault`=0, `fault_pc`=0, `fetch_count`=0.
- Fetch-to-output latency: 1 cycle (instruction addressed in cycle N is at head in N+1 if FIFO was empty).
- Redirect penalty: redirect in cycle N → `out_valid`=0 in N+1 → target instruction valid in N+2.
- Sustained throughput: 1 instruction/cycle with `out_ready` held high.
- Backpressure: `out_ready`=0 for ≥2 cycles fills FIFO; PC then stalls and `imem_pc` is held stable.
- `out_*` stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-operation: all state returns to reset values immediately, buffered entries discarded.

## Test plan
- Reset release, RESET_PC=0, imem words 0..3 = 0x00000013,0x00100093,0x00200113,0x00300193, `out_ready`=1 → cycles 1–4 deliver pc 0,4,8,12 with matching instr; fetch_count=4.
- Backpressure: `out_ready`=0 cycles 1–4 → FIFO holds pc 0 and 4, `imem_pc` stuck at 8; release → pc 0,4,8 delivered in order, no loss/duplication.
- Redirect to 0x40 in cycle 3 while head pc=8 accepted → pc 8 counted, cycle 4 `out_valid`=0, cycle 5 `out_pc`=0x40.
- Redirect to 0x42 → `fault`=1, `fault_pc`=0x42, `out_valid`=0 next cycle and stays 0; redirect to 0x10 afterwards leaves fault set.
- IMEM_DEPTH=4, sequential run from 0 → pc 0..12 delivered, then `fault`=1, `fault_pc`=0x10, no further output.
- Assert `rst_n` low mid-stream with FIFO full → all outputs at reset values same cycle; after release fetch resumes at RESET_PC.
